cache_set_assoc: RTL and testbench
==================================

# cache_set_assoc

Parametrised N-way set-associative cache set with true-LRU replacement and write-back, write-allocate policy. It holds WAYS lines of one set and services one byte read or write per request over a valid/ready handshake. On a miss it evicts a dirty victim and refills through a block-wide memory port. The top-level cache instantiates one per set index and routes requests by index bits.

## Interface
- ADDR_W, 32, request address width
- TAG_W, 19, tag width, taken from address bits [ADDR_W-1 -: TAG_W]
- WAYS, 4, associativity, power of two, 2..8
- BLOCK_BYTES, 16, line size in bytes, power of two; OFF_W = clog2(BLOCK_BYTES)
- clk  in  1  clock
- rst_b  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address; offset = req_addr[OFF_W-1:0]
- req_wdata  in  8  write byte
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  8  read byte, or written byte echoed on a write
- rsp_hit  out  1  1 if the request hit without a refill
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = write-back, 0 = refill read
- mem_req_addr  out  ADDR_W  block-aligned address {tag, set bits from req_addr, zero offset}
- mem_wdata  out  8*BLOCK_BYTES  evicted block
- mem_rsp_valid  in  1  refill data valid
- mem_rdata  in  8*BLOCK_BYTES  refill block; byte k at bits [8k+7:8k]

## Operation
- Per way: valid, dirty, tag, block, age (clog2(WAYS) bits).
- Hit = valid & tag match; at most one way hits.
- FSM states: IDLE, RESP, WB, FILL_REQ, FILL_WAIT.
- IDLE: req_ready=1. On req_valid, latch request, look up. Hit: read byte or write byte and set dirty; go to RESP with rsp_hit=1. Miss: pick victim; if victim valid & dirty go to WB, else FILL_REQ.
- Victim: lowest-index invalid way; otherwise the way with age WAYS-1.
- WB: mem_req_valid=1, mem_req_write=1, address {victim tag, set bits}; on mem_req_ready go to FILL_REQ. No write-back response is expected.
- FILL_REQ: mem_req_valid=1, mem_req_write=0, address of the request block; on mem_req_ready go to FILL_WAIT.
- FILL_WAIT: on mem_rsp_valid install the block, tag, valid=1, dirty=0; apply the pending write (dirty=1); go to RESP with rsp_hit=0.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- LRU update on every completed access to way w: ways with age < age[w] increment; age[w] = 0. Ages remain a permutation of 0..WAYS-1.
- mem_req_* held stable while mem_req_valid=1 and not ready.

## Timing
- Reset values: all valid=0, dirty=0, tag=0, blocks=0, age[i]=i. State IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_hit=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_wdata=0.
- Hit latency: accepted at edge N, rsp_valid high in cycle N+1.
- Clean miss: FILL_REQ at N+1. Response one cycle after the mem_rsp_valid edge.
- Dirty miss adds WB plus its handshake wait.
- req_ready=0 in all states except IDLE. A request presented then is not accepted.
- mem_rsp_valid outside FILL_WAIT is ignored.
- Reset mid-miss aborts immediately: FSM to IDLE, outputs to reset values, contents lost.

## Configuration
- CACHE_STATS_EN defined: adds outputs hit_cnt and miss_cnt (16 bits each). Each increments once per RESP according to rsp_hit, saturates at 16'hFFFF, and resets to 0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- cache_pkg: state enum; clog2-derived constants (OFF_W, AGE_W); function for the block-aligned address.
- Sub-module cache_way_store: one way's storage (valid, dirty, tag, block, age), tag compare, byte read/write port, install port. Instantiated WAYS times via generate.
- LRU update and victim select live in cache_set_assoc.

## Test plan
- Reset, then read 0x0000_1004 -> miss, FILL_REQ at 0x0000_1000. Refill with byte k = k -> rsp_data=0x04, rsp_hit=0, way0 valid.
- Read 0x0000_1004 again -> rsp_valid exactly 1 cycle after accept, rsp_data=0x04, rsp_hit=1, no mem request.
- Write 0xA5 to 0x0000_1007, then read it -> both hits, read returns 0xA5, way0 dirty.
- Fill 4 distinct tags, touch in order 0,1,2,3, then miss a 5th tag -> way0 evicted. WB issued with the 0xA5 block before FILL_REQ.
- Hold mem_req_ready=0 for 5 cycles during FILL_REQ -> mem_req_addr stable and req_ready=0 throughout.
- Assert rst_b low during FILL_WAIT -> IDLE, all lines invalid, age[i]=i. With CACHE_STATS_EN, hit_cnt=miss_cnt=0.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and helpers for the set-associative cache set:
//   state_e     - controller FSM states
//   off_w_f     - byte-offset width for a given line size
//   age_w_f     - LRU age / way-index width for a given associativity
//   block_align - clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESP,
    ST_WB,
    ST_FILL_REQ,
    ST_FILL_WAIT
  } state_e;

  function automatic int unsigned off_w_f(input int unsigned block_bytes);
    return $clog2(block_bytes);
  endfunction

  function automatic int unsigned age_w_f(input int unsigned ways);
    return $clog2(ways);
  endfunction

  // Operates on a 64-bit container; callers truncate to their address width.
  function automatic logic [63:0] block_align(input logic [63:0] addr,
                                              input int unsigned off_w);
    logic [63:0] mask;
    mask = ~64'd0 << off_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_way_store.sv
// -----------------------------------------------------------------------------
// cache_way_store
// Storage for one way of a cache set: valid, dirty, tag, data block and LRU age.
// Ports:
//   clk, rst_b            clock, asynchronous active-low reset
//   lkp_tag_i / hit_o     tag compare against the lookup tag (qualified by valid)
//   rd_off_i / rd_byte_o  combinational byte read
//   wr_en_i, wr_off_i, wr_byte_i    byte write, marks the line dirty
//   inst_en_i, inst_tag_i, inst_blk_i  install a refilled line (valid, clean)
//   age_en_i, age_in_i    LRU age update
//   valid_o, dirty_o, tag_o, blk_o, age_o  current line state
// An install and a write in the same cycle apply the write on top of the
// freshly installed block, leaving the line dirty (write-allocate).
// -----------------------------------------------------------------------------
module cache_way_store
  import cache_pkg::*;
#(
  parameter int TAG_W       = 19,
  parameter int BLOCK_BYTES = 16,
  parameter int OFF_W       = 4,
  parameter int AGE_W       = 2,
  parameter int INIT_AGE    = 0
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [TAG_W-1:0]         lkp_tag_i,
  output logic                     hit_o,
  input  logic [OFF_W-1:0]         rd_off_i,
  output logic [7:0]               rd_byte_o,
  input  logic                     wr_en_i,
  input  logic [OFF_W-1:0]         wr_off_i,
  input  logic [7:0]               wr_byte_i,
  input  logic                     inst_en_i,
  input  logic [TAG_W-1:0]         inst_tag_i,
  input  logic [8*BLOCK_BYTES-1:0] inst_blk_i,
  input  logic                     age_en_i,
  input  logic [AGE_W-1:0]         age_in_i,
  output logic                     valid_o,
  output logic                     dirty_o,
  output logic [TAG_W-1:0]         tag_o,
  output logic [8*BLOCK_BYTES-1:0] blk_o,
  output logic [AGE_W-1:0]         age_o
);

  logic                     valid_q, valid_d;
  logic                     dirty_q, dirty_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [8*BLOCK_BYTES-1:0] blk_q, blk_d;
  logic [AGE_W-1:0]         age_q, age_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    blk_d   = blk_q;
    age_d   = age_q;
    if (inst_en_i) begin
      valid_d = 1'b1;
      dirty_d = 1'b0;
      tag_d   = inst_tag_i;
      blk_d   = inst_blk_i;
    end
    if (wr_en_i) begin
      blk_d[{wr_off_i, 3'b000} +: 8] = wr_byte_i;
      dirty_d = 1'b1;
    end
    if (age_en_i) age_d = age_in_i;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q   <= '0;
      blk_q   <= '0;
      age_q   <= AGE_W'(INIT_AGE);
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      blk_q   <= blk_d;
      age_q   <= age_d;
    end
  end

  assign hit_o     = valid_q && (tag_q == lkp_tag_i);
  assign rd_byte_o = blk_q[{rd_off_i, 3'b000} +: 8];
  assign valid_o   = valid_q;
  assign dirty_o   = dirty_q;
  assign tag_o     = tag_q;
  assign blk_o     = blk_q;
  assign age_o     = age_q;

endmodule

// File: rtl/cache_set_assoc.sv
// -----------------------------------------------------------------------------
// cache_set_assoc
// One set of an N-way set-associative, write-back / write-allocate cache with
// true-LRU replacement. Services one byte read or write per request.
// Ports:
//   clk, rst_b                       clock, asynchronous active-low reset
//   req_valid_i/req_ready_o          request handshake (ready only in IDLE)
//   req_write_i, req_addr_i, req_wdata_i  request fields
//   rsp_valid_o, rsp_data_o, rsp_hit_o    one-cycle response strobe and data
//   mem_req_valid_o/mem_req_ready_i  memory request handshake
//   mem_req_write_o, mem_req_addr_o, mem_wdata_o  write-back or refill request
//   mem_rsp_valid_i, mem_rdata_i     refill data
//   hit_cnt_o, miss_cnt_o            saturating statistics (CACHE_STATS_EN only)
// Build option: define CACHE_STATS_EN to add the hit/miss counters.
// -----------------------------------------------------------------------------
module cache_set_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TAG_W       = 19,
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [ADDR_W-1:0]        req_addr_i,
  input  logic [7:0]               req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [7:0]               rsp_data_o,
  output logic                     rsp_hit_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic                     mem_req_write_o,
  output logic [ADDR_W-1:0]        mem_req_addr_o,
  output logic [8*BLOCK_BYTES-1:0] mem_wdata_o,
  input  logic                     mem_rsp_valid_i,
  input  logic [8*BLOCK_BYTES-1:0] mem_rdata_i
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]              hit_cnt_o,
  output logic [15:0]              miss_cnt_o
`endif
);

  localparam int OFF_W  = off_w_f(BLOCK_BYTES);
  localparam int AGE_W  = age_w_f(WAYS);
  localparam int BLK_W  = 8 * BLOCK_BYTES;
  localparam int SET_HI = ADDR_W - TAG_W - 1;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] req_addr_q;
  logic              req_write_q;
  logic [7:0]        req_wdata_q;
  logic [AGE_W-1:0]  victim_q;
  logic [7:0]        rsp_data_q;
  logic              rsp_hit_q;

  logic [WAYS-1:0]  way_valid, way_dirty, way_hit;
  logic [TAG_W-1:0] way_tag   [WAYS];
  logic [BLK_W-1:0] way_blk   [WAYS];
  logic [AGE_W-1:0] way_age   [WAYS];
  logic [7:0]       way_rbyte [WAYS];
  logic [AGE_W-1:0] age_new   [WAYS];
  logic [WAYS-1:0]  wr_en, inst_en;

  logic [TAG_W-1:0] lkp_tag;
  logic [OFF_W-1:0] lkp_off, wr_off;
  logic [7:0]       wr_byte, fill_byte;
  logic             any_hit, found;
  logic [AGE_W-1:0] hit_idx, vict, acc_way, acc_age;
  logic             accept, hit_acc, fill_done, touch;

  assign lkp_tag   = req_addr_i[ADDR_W-1 -: TAG_W];
  assign lkp_off   = req_addr_i[OFF_W-1:0];
  assign accept    = (state_q == ST_IDLE) && req_valid_i;
  assign hit_acc   = accept && any_hit;
  assign fill_done = (state_q == ST_FILL_WAIT) && mem_rsp_valid_i;
  assign touch     = hit_acc || fill_done;
  assign fill_byte = mem_rdata_i[{req_addr_q[OFF_W-1:0], 3'b000} +: 8];

  // Hit way encode; the tag store guarantees at most one way matches.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (way_hit[i]) begin
        any_hit = 1'b1;
        hit_idx = AGE_W'(i);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the least recently used way.
  always_comb begin
    vict  = '0;
    found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !way_valid[i]) begin
        vict  = AGE_W'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < WAYS; i++) begin
        if (way_age[i] == AGE_W'(WAYS - 1)) vict = AGE_W'(i);
      end
    end
  end

  // A hit completes in IDLE against the live request; a refill completes in
  // FILL_WAIT against the latched request and the victim way.
  assign acc_way = hit_acc ? hit_idx : victim_q;
  assign acc_age = way_age[acc_way];
  assign wr_off  = (state_q == ST_IDLE) ? lkp_off : req_addr_q[OFF_W-1:0];
  assign wr_byte = (state_q == ST_IDLE) ? req_wdata_i : req_wdata_q;

  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      wr_en[i]   = (hit_acc && req_write_i && (hit_idx == AGE_W'(i))) ||
                   (fill_done && req_write_q && (victim_q == AGE_W'(i)));
      inst_en[i] = fill_done && (victim_q == AGE_W'(i));
      // True LRU: younger ways age by one, the accessed way becomes youngest.
      if (AGE_W'(i) == acc_way)     age_new[i] = '0;
      else if (way_age[i] < acc_age) age_new[i] = way_age[i] + 1'b1;
      else                           age_new[i] = way_age[i];
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_store #(
      .TAG_W       (TAG_W),
      .BLOCK_BYTES (BLOCK_BYTES),
      .OFF_W       (OFF_W),
      .AGE_W       (AGE_W),
      .INIT_AGE    (g)
    ) u_way (
      .clk        (clk),
      .rst_b      (rst_b),
      .lkp_tag_i  (lkp_tag),
      .hit_o      (way_hit[g]),
      .rd_off_i   (lkp_off),
      .rd_byte_o  (way_rbyte[g]),
      .wr_en_i    (wr_en[g]),
      .wr_off_i   (wr_off),
      .wr_byte_i  (wr_byte),
      .inst_en_i  (inst_en[g]),
      .inst_tag_i (req_addr_q[ADDR_W-1 -: TAG_W]),
      .inst_blk_i (mem_rdata_i),
      .age_en_i   (touch),
      .age_in_i   (age_new[g]),
      .valid_o    (way_valid[g]),
      .dirty_o    (way_dirty[g]),
      .tag_o      (way_tag[g]),
      .blk_o      (way_blk[g]),
      .age_o      (way_age[g])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (any_hit)                              state_d = ST_RESP;
          else if (way_valid[vict] && way_dirty[vict]) state_d = ST_WB;
          else                                      state_d = ST_FILL_REQ;
        end
      end
      ST_RESP:      state_d = ST_IDLE;
      ST_WB:        if (mem_req_ready_i) state_d = ST_FILL_REQ;
      ST_FILL_REQ:  if (mem_req_ready_i) state_d = ST_FILL_WAIT;
      ST_FILL_WAIT: if (mem_rsp_valid_i) state_d = ST_RESP;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Memory request fields depend only on state and latched registers, so they
  // stay stable for as long as the memory side withholds ready.
  always_comb begin
    req_ready_o     = (state_q == ST_IDLE);
    rsp_valid_o     = (state_q == ST_RESP);
    mem_req_valid_o = 1'b0;
    mem_req_write_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_wdata_o     = '0;
    if (state_q == ST_WB) begin
      mem_req_valid_o = 1'b1;
      mem_req_write_o = 1'b1;
      mem_req_addr_o  = {way_tag[victim_q], req_addr_q[SET_HI:OFF_W], {OFF_W{1'b0}}};
      mem_wdata_o     = way_blk[victim_q];
    end else if (state_q == ST_FILL_REQ) begin
      mem_req_valid_o = 1'b1;
      mem_req_addr_o  = ADDR_W'(block_align(64'(req_addr_q), OFF_W));
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_addr_q  <= req_addr_i;
        req_write_q <= req_write_i;
        req_wdata_q <= req_wdata_i;
        victim_q    <= vict;
      end
      if (hit_acc) begin
        rsp_data_q <= req_write_i ? req_wdata_i : way_rbyte[hit_idx];
        rsp_hit_q  <= 1'b1;
      end else if (fill_done) begin
        rsp_data_q <= req_write_q ? req_wdata_q : fill_byte;
        rsp_hit_q  <= 1'b0;
      end
    end
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_hit_o  = rsp_hit_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == ST_RESP) begin
      if (rsp_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_set_assoc.sv
// -----------------------------------------------------------------------------
// tb_cache_set_assoc
// Directed bench for cache_set_assoc (default parameters). A vector table holds
// request sequences with hand-computed results; hand-written sequences cover the
// memory-stall and reset-mid-miss cases. Refill data for a block whose tag is T
// is byte k = T*16 + k. Define CACHE_STATS_EN to also cover the counters.
// -----------------------------------------------------------------------------
module tb_cache_set_assoc;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr;
  logic [7:0]   req_wdata;
  logic         rsp_valid, rsp_hit;
  logic [7:0]   rsp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_wdata;
  logic         mem_rsp_valid;
  logic [127:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0]  hit_cnt, miss_cnt;
`endif

  cache_set_assoc dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_write_i     (req_write),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .rsp_valid_o     (rsp_valid),
    .rsp_data_o      (rsp_data),
    .rsp_hit_o       (rsp_hit),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_write_o (mem_req_write),
    .mem_req_addr_o  (mem_req_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rdata_i     (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt_o       (hit_cnt),
    .miss_cnt_o      (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [7:0]   wd;
    logic [7:0]   e_data;
    logic         e_hit;
    int           e_lat;
    logic         e_wb;
    logic [31:0]  e_wb_addr;
    logic [127:0] e_wb_data;
    logic [31:0]  e_fill;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  // Results of the last do_req
  logic [7:0]   r_data;
  logic         r_hit, r_wb, r_fill, r_done;
  int           r_lat;
  logic [31:0]  r_wb_addr, r_fill_addr;
  logic [127:0] r_wb_data;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] fill_blk(input logic [31:0] a);
    logic [127:0] b;
    logic [7:0]   base;
    base = {a[16:13], 4'h0};
    for (int k = 0; k < 16; k++) b[8*k +: 8] = base + 8'(k);
    return b;
  endfunction

  // Issue one request with mem_req_ready held high; refill data is returned the
  // cycle after each refill handshake. Latency counts negedges after acceptance.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [7:0] wd);
    bit pend, done;
    r_data = '0; r_hit = 1'b0; r_lat = 0; r_wb = 1'b0; r_wb_addr = '0;
    r_wb_data = '0; r_fill = 1'b0; r_fill_addr = '0;
    pend = 1'b0; done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    mem_req_ready = 1'b1;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      req_valid     = 1'b0;
      mem_rsp_valid = 1'b0;
      if (pend) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = fill_blk(r_fill_addr);
        pend          = 1'b0;
      end
      if (rsp_valid) begin
        r_data = rsp_data; r_hit = rsp_hit; r_lat = c; done = 1'b1;
      end else if (mem_req_valid && mem_req_ready) begin
        if (mem_req_write) begin
          r_wb = 1'b1; r_wb_addr = mem_req_addr; r_wb_data = mem_wdata;
        end else begin
          r_fill = 1'b1; r_fill_addr = mem_req_addr; pend = 1'b1;
        end
      end
    end
    mem_rsp_valid = 1'b0;
    r_done = done;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_data"}, rsp_data, 8'h00);
    chk({tag, "_rsp_hit"}, rsp_hit, 1'b0);
    chk({tag, "_mem_valid"}, mem_req_valid, 1'b0);
    chk({tag, "_mem_write"}, mem_req_write, 1'b0);
    chk({tag, "_mem_addr"}, mem_req_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 128'h0);
    chk({tag, "_valid"}, {dut.g_way[3].u_way.valid_q, dut.g_way[2].u_way.valid_q,
                          dut.g_way[1].u_way.valid_q, dut.g_way[0].u_way.valid_q}, 4'b0000);
    chk({tag, "_ages"}, {dut.g_way[3].u_way.age_q, dut.g_way[2].u_way.age_q,
                         dut.g_way[1].u_way.age_q, dut.g_way[0].u_way.age_q}, 8'b11_10_01_00);
`ifdef CACHE_STATS_EN
    chk({tag, "_hit_cnt"}, hit_cnt, 16'd0);
    chk({tag, "_miss_cnt"}, miss_cnt, 16'd0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          wr    addr          wd     data   hit  lat wb    wb_addr       wb_data                                   fill
    vecs[0]  = '{1'b0, 32'h0000_1004, 8'h00, 8'h04, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_1000};
    vecs[1]  = '{1'b0, 32'h0000_1004, 8'h00, 8'h04, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[2]  = '{1'b1, 32'h0000_1007, 8'hA5, 8'hA5, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_1007, 8'h00, 8'hA5, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_3000, 8'h00, 8'h10, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_3000};
    vecs[5]  = '{1'b0, 32'h0000_5001, 8'h00, 8'h21, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_5000};
    vecs[6]  = '{1'b0, 32'h0000_7002, 8'h00, 8'h32, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_7000};
    vecs[7]  = '{1'b0, 32'h0000_1007, 8'h00, 8'hA5, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_3003, 8'h00, 8'h13, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_5004, 8'h00, 8'h24, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_7005, 8'h00, 8'h35, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_9006, 8'h00, 8'h46, 1'b0, 4, 1'b1, 32'h0000_1000,
                 128'h0F0E0D0C_0B0A0908_A5060504_03020100, 32'h0000_9000};
    vecs[12] = '{1'b1, 32'h0000_3008, 8'h77, 8'h77, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_1000, 8'h00, 8'h00, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_1000};
    vecs[14] = '{1'b0, 32'h0000_5000, 8'h00, 8'h20, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_5000};
    vecs[15] = '{1'b0, 32'h0000_7000, 8'h00, 8'h30, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_7000};
    vecs[16] = '{1'b0, 32'h0000_9000, 8'h00, 8'h40, 1'b0, 4, 1'b1, 32'h0000_3000,
                 128'h1F1E1D1C_1B1A1977_17161514_13121110, 32'h0000_9000};
    vecs[17] = '{1'b1, 32'h0000_B00F, 8'hEE, 8'hEE, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_B000};
    vecs[18] = '{1'b0, 32'h0000_B00F, 8'h00, 8'hEE, 1'b1, 1, 1'b0, 32'h0, 128'h0, 32'h0};
    vecs[19] = '{1'b0, 32'h0000_1000, 8'h00, 8'h00, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_1000};
    vecs[20] = '{1'b0, 32'h0000_D000, 8'h00, 8'h60, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_D000};
    vecs[21] = '{1'b0, 32'h0000_F000, 8'h00, 8'h70, 1'b0, 3, 1'b0, 32'h0, 128'h0, 32'h0000_F000};
    vecs[22] = '{1'b0, 32'h0001_1000, 8'h00, 8'h80, 1'b0, 4, 1'b1, 32'h0000_B000,
                 128'hEE5E5D5C_5B5A5958_57565554_53525150, 32'h0001_1000};

    rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_in");
    rst_b = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_out");

    for (int i = 0; i < NVEC; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wd);
      chk($sformatf("v%0d_done", i), r_done, 1'b1);
      chk($sformatf("v%0d_data", i), r_data, vecs[i].e_data);
      chk($sformatf("v%0d_hit", i), r_hit, vecs[i].e_hit);
      chk($sformatf("v%0d_lat", i), 128'(r_lat), 128'(vecs[i].e_lat));
      chk($sformatf("v%0d_wb", i), r_wb, vecs[i].e_wb);
      chk($sformatf("v%0d_fill", i), r_fill, !vecs[i].e_hit);
      if (vecs[i].e_wb) begin
        chk($sformatf("v%0d_wb_addr", i), r_wb_addr, vecs[i].e_wb_addr);
        chk($sformatf("v%0d_wb_data", i), r_wb_data, vecs[i].e_wb_data);
      end
      if (!vecs[i].e_hit) chk($sformatf("v%0d_fill_addr", i), r_fill_addr, vecs[i].e_fill);
      if (i == 3) chk("way0_dirty", dut.g_way[0].u_way.dirty_q, 1'b1);
    end

    // Memory stall during FILL_REQ; a stray request and a stray refill pulse
    // arrive while the block is busy and must both be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0001_3000; mem_req_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h0000_1000; req_wdata = 8'h55;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      mem_rsp_valid = (c == 2);
      mem_rdata     = {16{8'hCC}};
      chk($sformatf("stall%0d_valid", c), mem_req_valid, 1'b1);
      chk($sformatf("stall%0d_write", c), mem_req_write, 1'b0);
      chk($sformatf("stall%0d_addr", c), mem_req_addr, 32'h0001_3000);
      chk($sformatf("stall%0d_ready", c), req_ready, 1'b0);
    end
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    chk("stall_wait_valid", mem_req_valid, 1'b0);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = fill_blk(32'h0001_3000);
    @(negedge clk);
    mem_rsp_valid = 1'b0; req_valid = 1'b0;
    chk("stall_rsp_valid", rsp_valid, 1'b1);
    chk("stall_rsp_data", rsp_data, 8'h90);
    chk("stall_rsp_hit", rsp_hit, 1'b0);
    @(negedge clk);
    chk("stall_idle_ready", req_ready, 1'b1);
    chk("stall_idle_mem", mem_req_valid, 1'b0);
`ifdef CACHE_STATS_EN
    chk("stats_hit_cnt", hit_cnt, 16'd9);
    chk("stats_miss_cnt", miss_cnt, 16'd15);
`endif

    // Reset asserted while waiting for refill data.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0001_5000; mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmiss_fill_req", mem_req_valid, 1'b1);
    chk("rstmiss_fill_wr", mem_req_write, 1'b0);
    @(negedge clk);
    chk("rstmiss_in_wait", mem_req_valid, 1'b0);
    chk("rstmiss_busy", req_ready, 1'b0);
    #2 rst_b = 1'b0;
    #1;
    chk_reset_outputs("rstmiss");
    @(negedge clk);
    rst_b = 1'b1;

    // Tag 8 was resident before reset; it must now miss into way 0.
    do_req(1'b0, 32'h0001_1000, 8'h00);
    chk("post_rst_done", r_done, 1'b1);
    chk("post_rst_hit", r_hit, 1'b0);
    chk("post_rst_data", r_data, 8'h80);
    chk("post_rst_lat", 128'(r_lat), 128'(3));
    chk("post_rst_fill", r_fill_addr, 32'h0001_1000);
    chk("post_rst_way0", dut.g_way[0].u_way.valid_q, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
